kaly_key_add: RTL

Round-key addition stage for the Kalyna-128 datapath. It sits directly downstream of the MixColumns stage. It takes the 128-bit MixColumns output state and a 128-bit round key, and produces the next-round state. Two modes are supported: bytewise XOR for middle rounds, and per-column addition modulo 2^64 for whitening rounds. Additions use a single 32-bit adder iterated over four cycles. Both sides use a valid/ready handshake, and the output register holds its data under backpressure.

---
 rtl/kaly_key_add.sv | 129 ++++++++++++
 1 files changed

// File: rtl/kaly_key_add.sv
// rtl/kaly_key_add.sv - Kalyna-128 round-key addition stage (XOR or per-column add mod 2^64)
module kaly_key_add (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [127:0] in_key,
  input  logic         in_mode_add,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  // The XOR and ADD states double as the latched mode bit.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XOR  = 2'd1,
    S_ADD  = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t        state;
  logic [127:0]  data_r;
  logic [127:0]  key_r;
  logic [1:0]    step;
  logic          carry;

  logic [63:0]   w0;
  logic [63:0]   w1;
  logic [63:0]   k0;
  logic [63:0]   k1;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic          cin;
  logic [32:0]   sum;
  logic [127:0]  add_next;
  int            base_row;
  int            col;

  // Acceptance only in IDLE, and never while reset is held.
  assign in_ready = (state == S_IDLE) && !rst;

  // Gather the interleaved bytes into column words, row 0 in the LSB.
  always_comb begin
    w0 = '0;
    w1 = '0;
    k0 = '0;
    k1 = '0;
    for (int r = 0; r < 8; r++) begin
      w0[8*r +: 8] = data_r[127 - 8*(2*r)     -: 8];
      w1[8*r +: 8] = data_r[127 - 8*(2*r + 1) -: 8];
      k0[8*r +: 8] = key_r[127 - 8*(2*r)      -: 8];
      k1[8*r +: 8] = key_r[127 - 8*(2*r + 1)  -: 8];
    end
  end

  // Single 32-bit adder: step[1] picks the column, step[0] the upper half.
  // Carry only feeds the upper half so each column wraps at 2^64.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (step)
      2'd0: begin op_a = w0[31:0];  op_b = k0[31:0];  end
      2'd1: begin op_a = w0[63:32]; op_b = k0[63:32]; end
      2'd2: begin op_a = w1[31:0];  op_b = k1[31:0];  end
      default: begin op_a = w1[63:32]; op_b = k1[63:32]; end
    endcase
    cin = step[0] & carry;
    sum = {1'b0, op_a} + {1'b0, op_b} + {32'd0, cin};
  end

  // Scatter the four result bytes of this slice back into the interleaved layout.
  always_comb begin
    add_next = out_data;
    base_row = step[0] ? 4 : 0;
    col      = step[1] ? 1 : 0;
    for (int r = 0; r < 4; r++) begin
      add_next[127 - 8*(2*(base_row + r) + col) -: 8] = sum[8*r +: 8];
    end
  end

  // Control FSM with registered output valid and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      data_r    <= '0;
      key_r     <= '0;
      step      <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            data_r <= in_data;
            key_r  <= in_key;
            step   <= '0;
            carry  <= 1'b0;
            state  <= in_mode_add ? S_ADD : S_XOR;
          end
        end
        S_XOR: begin
          out_data  <= data_r ^ key_r;
          out_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_ADD: begin
          out_data <= add_next;
          carry    <= sum[32];
          step     <= step + 2'd1;
          if (step == 2'd3) begin
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
